// File: rtl/conv_pkg.sv
// Shared types and helper functions for the sequential convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        EMIT,
        DONE
    } state_t;

    // Full-precision accumulator width for N products of two DW-bit samples
    function automatic int unsigned fw(input int unsigned dw, input int unsigned nn);
        return 2 * dw + $clog2(nn);
    endfunction

    // Output index width: covers n = 0 .. 2N-2
    function automatic int unsigned idx_w(input int unsigned nn);
        return $clog2(2 * nn - 1);
    endfunction

    function automatic int unsigned kmin(input int unsigned n, input int unsigned nn);
        return (n + 1 > nn) ? n + 1 - nn : 0;
    endfunction

    function automatic int unsigned kmax(input int unsigned n, input int unsigned nn);
        return (n < nn - 1) ? n : nn - 1;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Single multiply-accumulate stage: FW-bit accumulator with synchronous clear and enable.
module conv_mac #(
    parameter int unsigned DW = 4,
    parameter int unsigned FW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [FW-1:0] sum_c
);

    logic [FW-1:0] acc;
    logic [FW-1:0] prod;

    assign prod  = FW'(a) * FW'(b);
    assign sum_c = acc + prod;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum_c;
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// Sequential linear convolution of two N-sample vectors over one shared MAC.
// Optional macro CONV_SAT_EN: saturate (instead of truncate) results wider than OUT_W.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DW    = 4,
    parameter int unsigned OUT_W = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [N*DW-1:0]       x_in,
    input  logic [N*DW-1:0]       h_in,
    output logic                  busy,
    output logic [OUT_W-1:0]      y_out,
    output logic [idx_w(N)-1:0]   y_idx,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic                  done
);

    localparam int unsigned FW   = fw(DW, N);
    localparam int unsigned IW   = idx_w(N);
    localparam int unsigned KW   = $clog2(N);
    localparam int unsigned LAST = 2 * N - 2;

    state_t           state, state_nxt;
    logic [IW-1:0]    n, n_nxt;
    logic [KW-1:0]    k, k_nxt;
    logic [KW-1:0]    hk;
    logic [DW-1:0]    x_r [N];
    logic [DW-1:0]    h_r [N];
    logic             load_c;
    logic             acc_clr;
    logic             acc_en;
    logic [FW-1:0]    sum_c;
    logic [OUT_W-1:0] y_out_nxt;
    logic [IW-1:0]    y_idx_nxt;

    // Reduce the full-precision accumulator to the output width
    function automatic logic [OUT_W-1:0] reduce(input logic [FW-1:0] a);
`ifdef CONV_SAT_EN
        if ((a >> OUT_W) != '0) begin
            return '1;
        end
`endif
        return OUT_W'(a);
    endfunction

    // h index n-k always lies in 0..N-1 while k is within [kmin(n), kmax(n)]
    assign hk = KW'(n - IW'(k));

    conv_mac #(
        .DW (DW),
        .FW (FW)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (acc_en),
        .a     (x_r[k]),
        .b     (h_r[hk]),
        .sum_c (sum_c)
    );

    always_comb begin
        state_nxt = state;
        n_nxt     = n;
        k_nxt     = k;
        load_c    = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        y_out_nxt = y_out;
        y_idx_nxt = y_idx;
        case (state)
            IDLE: begin
                if (start) begin
                    load_c    = 1'b1;
                    n_nxt     = '0;
                    k_nxt     = KW'(kmin(0, N));
                    acc_clr   = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                acc_en = 1'b1;
                if (k == KW'(kmax(32'(n), N))) begin
                    // Sample is latched from the final sum so it appears with EMIT
                    y_out_nxt = reduce(sum_c);
                    y_idx_nxt = n;
                    state_nxt = EMIT;
                end else begin
                    k_nxt = k + KW'(1);
                end
            end
            EMIT: begin
                if (y_ready) begin
                    if (n == IW'(LAST)) begin
                        state_nxt = DONE;
                    end else begin
                        n_nxt     = n + IW'(1);
                        k_nxt     = KW'(kmin(32'(n) + 1, N));
                        acc_clr   = 1'b1;
                        state_nxt = MAC;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            n       <= '0;
            k       <= '0;
            busy    <= 1'b0;
            y_valid <= 1'b0;
            done    <= 1'b0;
            y_out   <= '0;
            y_idx   <= '0;
        end else begin
            state   <= state_nxt;
            n       <= n_nxt;
            k       <= k_nxt;
            busy    <= (state_nxt != IDLE);
            y_valid <= (state_nxt == EMIT);
            done    <= (state_nxt == DONE);
            y_out   <= y_out_nxt;
            y_idx   <= y_idx_nxt;
        end
    end

    // Operand capture; contents only matter once a run has started
    always_ff @(posedge clk) begin
        if (load_c) begin
            for (int i = 0; i < N; i++) begin
                x_r[i] <= x_in[i*DW +: DW];
                h_r[i] <= h_in[i*DW +: DW];
            end
        end
    end

endmodule
